// File: rtl/alu_seq_ctrl.sv
// Sequencer that steps operands and an opcode into an external ALU from a push button, then captures the result.
// Optional button debounce is enabled by defining ALU_SEQ_CTRL_DEBOUNCE_EN.
module alu_seq_ctrl #(
  parameter int NB_DATA         = 8,
  parameter int NB_OP           = 6,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_switches,
  input  logic               i_boton,
  input  logic [NB_DATA-1:0] i_alu_res,
  input  logic               i_alu_carry,
  output logic [NB_DATA-1:0] o_dato_a,
  output logic [NB_DATA-1:0] o_dato_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_res,
  output logic               o_carry,
  output logic               o_valid,
  output logic [2:0]         o_state
);

  typedef enum logic [2:0] {
    S_LOAD_A  = 3'd0,
    S_LOAD_B  = 3'd1,
    S_LOAD_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_CAPT    = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic                 lvl;
  logic                 lvl_prev_q, lvl_prev_d;
  logic                 step_q, step_d;
  logic [NB_DATA-1:0]   dato_a_q, dato_a_d;
  logic [NB_DATA-1:0]   dato_b_q, dato_b_d;
  logic [NB_OP-1:0]     op_q, op_d;
  logic [NB_DATA-1:0]   res_q, res_d;
  logic                 carry_q, carry_d;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_boton;
      sync2_q <= sync1_q;
    end
  end

`ifdef ALU_SEQ_CTRL_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Level flips only after the synchronized input has disagreed for DEBOUNCE_CYCLES edges in a row.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == CNT_LAST) lvl_d = sync2_q;
      else                   cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      lvl_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  assign lvl = lvl_q;
`else
  assign lvl = sync2_q;
`endif

  // Registered edge detect gives a one-cycle step, 3 cycles after the raw press without debounce.
  always_comb begin
    lvl_prev_d = lvl;
    step_d     = lvl & ~lvl_prev_q;
  end

  always_comb begin
    state_d  = state_q;
    dato_a_d = dato_a_q;
    dato_b_d = dato_b_q;
    op_d     = op_q;
    res_d    = res_q;
    carry_d  = carry_q;
    case (state_q)
      S_LOAD_A:  if (step_q) begin dato_a_d = i_switches;            state_d = S_LOAD_B;  end
      S_LOAD_B:  if (step_q) begin dato_b_d = i_switches;            state_d = S_LOAD_OP; end
      S_LOAD_OP: if (step_q) begin op_d     = i_switches[NB_OP-1:0]; state_d = S_EXEC;    end
      S_EXEC:    state_d = S_CAPT;
      S_CAPT: begin
        res_d   = i_alu_res;
        carry_d = i_alu_carry;
        state_d = S_LOAD_A;
      end
      default:   state_d = S_LOAD_A;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_LOAD_A;
      lvl_prev_q <= 1'b0;
      step_q     <= 1'b0;
      dato_a_q   <= '0;
      dato_b_q   <= '0;
      op_q       <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lvl_prev_q <= lvl_prev_d;
      step_q     <= step_d;
      dato_a_q   <= dato_a_d;
      dato_b_q   <= dato_b_d;
      op_q       <= op_d;
      res_q      <= res_d;
      carry_q    <= carry_d;
    end
  end

  assign o_dato_a = dato_a_q;
  assign o_dato_b = dato_b_q;
  assign o_op     = op_q;
  assign o_res    = res_q;
  assign o_carry  = carry_q;
  assign o_valid  = (state_q == S_CAPT);
  assign o_state  = state_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed vector table, corner-case sequences and random rounds
// checked against a step-counting reference model with a simple external ALU model.
module tb_alu_seq_ctrl;

`ifdef ALU_SEQ_CTRL_DEBOUNCE_EN
  localparam int LAT = 3 + 4;
`else
  localparam int LAT = 3;
`endif

  logic       i_clk, i_reset, i_boton, i_alu_carry, o_carry, o_valid;
  logic [7:0] i_switches, i_alu_res, o_dato_a, o_dato_b, o_res;
  logic [5:0] o_op;
  logic [2:0] o_state;

  alu_seq_ctrl #(.NB_DATA(8), .NB_OP(6), .DEBOUNCE_CYCLES(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_switches(i_switches), .i_boton(i_boton),
    .i_alu_res(i_alu_res), .i_alu_carry(i_alu_carry),
    .o_dato_a(o_dato_a), .o_dato_b(o_dato_b), .o_op(o_op), .o_res(o_res),
    .o_carry(o_carry), .o_valid(o_valid), .o_state(o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op[1:0])
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {1'b0, a} - {1'b0, b};
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  always_comb {i_alu_carry, i_alu_res} = alu_f(o_dato_a, o_dato_b, o_op);

  int n_chk = 0;
  int n_fail = 0;
  int valid_cnt = 0;

  always @(negedge i_clk) if (o_valid === 1'b1) valid_cnt++;

  int         m_phase, m_vexp;
  logic [7:0] m_a, m_b, m_res;
  logic [5:0] m_op;
  logic       m_carry;

  logic [2:0] st_tr [0:31];
  logic       v_tr  [0:31];

  typedef struct {
    logic [7:0] sw;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [2:0] st;
    logic [7:0] res;
    logic       carry;
  } vec_t;

  vec_t tbl [3];

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic mdl_reset();
    m_phase = 0; m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_carry = 1'b0;
  endtask

  // One accepted step: the phase says which register it fills; the third one also produces a result.
  task automatic mdl_step(input logic [7:0] sw);
    case (m_phase)
      0: m_a = sw;
      1: m_b = sw;
      default: begin
        m_op = sw[5:0];
        {m_carry, m_res} = alu_f(m_a, m_b, m_op);
        m_vexp++;
      end
    endcase
    m_phase = (m_phase + 1) % 3;
  endtask

  task automatic check_model(input string nm);
    chk({nm, ".state"}, 32'(o_state), 32'(m_phase));
    chk({nm, ".a"},     32'(o_dato_a), 32'(m_a));
    chk({nm, ".b"},     32'(o_dato_b), 32'(m_b));
    chk({nm, ".op"},    32'(o_op), 32'(m_op));
    chk({nm, ".res"},   32'(o_res), 32'(m_res));
    chk({nm, ".carry"}, 32'(o_carry), 32'(m_carry));
    chk({nm, ".valid_count"}, 32'(valid_cnt), 32'(m_vexp));
  endtask

  task automatic press(input logic [7:0] sw);
    int k;
    k = 0;
    i_switches = sw;
    i_boton = 1'b1;
    repeat (LAT + 1) begin tick(); st_tr[k] = o_state; v_tr[k] = o_valid; k++; end
    i_boton = 1'b0;
    repeat (LAT + 3) begin tick(); st_tr[k] = o_state; v_tr[k] = o_valid; k++; end
    mdl_step(sw);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{sw: 8'h12, a: 8'h12, b: 8'h00, op: 6'h00, st: 3'd1, res: 8'h00, carry: 1'b0};
    tbl[1] = '{sw: 8'h34, a: 8'h12, b: 8'h34, op: 6'h00, st: 3'd2, res: 8'h00, carry: 1'b0};
    tbl[2] = '{sw: 8'h05, a: 8'h12, b: 8'h34, op: 6'h05, st: 3'd0, res: 8'hDE, carry: 1'b1};

    m_vexp = 0;
    mdl_reset();
    i_reset = 1'b0; i_boton = 1'b0; i_switches = 8'hFF;
    repeat (3) tick();
    chk("reset.state", 32'(o_state), 0);
    chk("reset.a", 32'(o_dato_a), 0);
    chk("reset.b", 32'(o_dato_b), 0);
    chk("reset.op", 32'(o_op), 0);
    chk("reset.res", 32'(o_res), 0);
    chk("reset.carry", 32'(o_carry), 0);
    chk("reset.valid", 32'(o_valid), 0);
    i_reset = 1'b1;
    repeat (2) tick();

    // Directed table: 0x12, 0x34, 0x05 then per-cycle trace of the final step.
    for (int i = 0; i < 3; i++) begin
      press(tbl[i].sw);
      chk($sformatf("tbl%0d.state", i), 32'(o_state), 32'(tbl[i].st));
      chk($sformatf("tbl%0d.a", i), 32'(o_dato_a), 32'(tbl[i].a));
      chk($sformatf("tbl%0d.b", i), 32'(o_dato_b), 32'(tbl[i].b));
      chk($sformatf("tbl%0d.op", i), 32'(o_op), 32'(tbl[i].op));
      chk($sformatf("tbl%0d.res", i), 32'(o_res), 32'(tbl[i].res));
      chk($sformatf("tbl%0d.carry", i), 32'(o_carry), 32'(tbl[i].carry));
      if (i == 2) begin
        chk("trace.step_cycle_state", 32'(st_tr[LAT-1]), 2);
        chk("trace.exec_state", 32'(st_tr[LAT]), 3);
        chk("trace.capt_state", 32'(st_tr[LAT+1]), 4);
        chk("trace.back_to_a", 32'(st_tr[LAT+2]), 0);
        chk("trace.valid_before", 32'(v_tr[LAT]), 0);
        chk("trace.valid_pulse", 32'(v_tr[LAT+1]), 1);
        chk("trace.valid_after", 32'(v_tr[LAT+2]), 0);
        chk("trace.valid_total", 32'(valid_cnt), 1);
      end
    end
    check_model("tbl_model");

    // Button held for 50 cycles: one step only, later switch changes are not loaded.
    i_switches = 8'h5A;
    i_boton = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (c == 15) i_switches = 8'hA5;
    end
    i_boton = 1'b0;
    repeat (LAT + 3) tick();
    mdl_step(8'h5A);
    check_model("held");

    press(8'h77);
    check_model("held_b");

`ifndef ALU_SEQ_CTRL_DEBOUNCE_EN
    // Press, release one cycle, re-press: the second step falls in the EXEC/CAPT window and must vanish.
    i_switches = 8'h3C;
    i_boton = 1'b1; tick();
    i_boton = 1'b0; tick();
    i_boton = 1'b1;
    repeat (LAT + 3) tick();
    i_boton = 1'b0;
    repeat (LAT + 3) tick();
    mdl_step(8'h3C);
    check_model("drop_step");
`else
    press(8'h3C);
    check_model("op_step");
`endif

    // Asynchronous reset between edges while in S_LOAD_OP.
    press(8'h11);
    press(8'h22);
    check_model("pre_reset");
    #3 i_reset = 1'b0;
    #1;
    chk("async.state", 32'(o_state), 0);
    chk("async.a", 32'(o_dato_a), 0);
    chk("async.b", 32'(o_dato_b), 0);
    chk("async.res", 32'(o_res), 0);
    chk("async.carry", 32'(o_carry), 0);
    #2 i_reset = 1'b1;
    mdl_reset();
    tick();
    press(8'h99);
    check_model("after_reset");

    // Button already high across reset release gives exactly one step.
    i_switches = 8'h66;
    i_boton = 1'b1;
    i_reset = 1'b0;
    #2 i_reset = 1'b1;
    mdl_reset();
    repeat (LAT + 1) tick();
    repeat (10) tick();
    i_boton = 1'b0;
    repeat (LAT + 3) tick();
    mdl_step(8'h66);
    check_model("held_thru_reset");

    for (int r = 0; r < 24; r++) begin
      press(8'($urandom));
      check_model($sformatf("rand%0d", r));
    end

`ifdef ALU_SEQ_CTRL_DEBOUNCE_EN
    i_reset = 1'b0;
    #2 i_reset = 1'b1;
    mdl_reset();
    tick();
    i_switches = 8'hC3;
    for (int t = 0; t < 5; t++) begin
      i_boton = 1'b1; repeat (2) tick();
      i_boton = 1'b0; repeat (2) tick();
    end
    chk("bounce.no_step", 32'(o_state), 0);
    i_boton = 1'b1;
    repeat (LAT) tick();
    chk("bounce.before_step", 32'(o_state), 0);
    tick();
    chk("bounce.step_taken", 32'(o_state), 1);
    chk("bounce.a", 32'(o_dato_a), 32'h0C3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
